// File: rtl/rob_book_responder.sv
// Reorder-buffer allocator: the responder side of the ROB booking handshake.
// It books in-order slots, accepts result fills from the execution pipes,
// retires the head slot in program order and broadcasts the retired result.
// A fault or a mispredicted next PC flushes every younger slot.
module rob_book_responder #(
  parameter int                  I_BL_MARC_REG = 4,
  parameter int                  I_BL_ARC_REG  = 5,
  parameter int                  D_BL_MARC_REG = 32,
  parameter int                  I_BL_ARC_PC   = 32,
  parameter int                  I_BL_ARC_PVL  = 2,
  parameter int                  D_BL_MARC_OP  = 6,
  parameter int                  I_BL_TRAPC    = 4,
  parameter logic [I_BL_ARC_PC-1:0] RESET_PC   = 32'h0,
  parameter logic [I_BL_ARC_PC-1:0] TRAP_PC    = 32'h100
) (
  input  logic                     c_clock,
  input  logic                     c_reset,
  input  logic                     c_pause,
  // booking request
  input  logic                     c_req,
  input  logic [I_BL_ARC_PC-1:0]   i_spec_pc,
  input  logic [I_BL_ARC_PVL-1:0]  i_spec_pvl,
  input  logic [I_BL_ARC_REG-1:0]  i_areg_rd,
  input  logic [D_BL_MARC_OP-1:0]  c_op,
  output logic                     s_book,
  output logic [I_BL_MARC_REG-1:0] i_preg_rd,
  // result fill
  input  logic [I_BL_MARC_REG-1:0] f_i_preg_rd,
  input  logic [D_BL_MARC_REG-1:0] f_d_preg_rd,
  input  logic [I_BL_ARC_PC-1:0]   f_i_arch_nextPc,
  input  logic [I_BL_TRAPC-1:0]    f_s_trapC,
  // commit broadcast
  output logic                     s_enable,
  output logic                     s_cur,
  output logic [I_BL_TRAPC-1:0]    s_cur_fcode,
  output logic                     s_spec,
  output logic [I_BL_ARC_PC-1:0]   cur_i_pc,
  output logic [I_BL_ARC_PVL-1:0]  cur_i_pvl,
  output logic [I_BL_ARC_PC-1:0]   recov_i_pc,
  output logic [I_BL_ARC_PVL-1:0]  recov_i_pvl,
  output logic [D_BL_MARC_OP-1:0]  c_op_cm,
  // physical-to-architectural register broadcast
  output logic [I_BL_MARC_REG-1:0] i_preg_rb1,
  output logic [I_BL_ARC_REG-1:0]  i_areg_rb1,
  output logic [D_BL_MARC_REG-1:0] d_preg_rb1
);

  localparam int N_SLOTS = 2 ** I_BL_MARC_REG;

  typedef logic [I_BL_MARC_REG-1:0] slot_t;

  // Slot 0 means "no slot", so the ring runs 1..LAST_SLOT.
  localparam slot_t FIRST_SLOT = slot_t'(1);
  localparam slot_t LAST_SLOT  = '1;

  // Control state
  logic [N_SLOTS-1:0]      r_valid;
  logic [N_SLOTS-1:0]      r_done;
  slot_t                   r_head;
  slot_t                   r_tail;
  slot_t                   r_count;
  logic [I_BL_ARC_PC-1:0]  r_arch_pc;
  logic [I_BL_ARC_PVL-1:0] r_arch_pvl;

  // Per-slot payload
  logic [I_BL_ARC_PC-1:0]   r_spec_pc  [N_SLOTS];
  logic [I_BL_ARC_PVL-1:0]  r_spec_pvl [N_SLOTS];
  logic [I_BL_ARC_REG-1:0]  r_areg_rd  [N_SLOTS];
  logic [D_BL_MARC_OP-1:0]  r_op       [N_SLOTS];
  logic [D_BL_MARC_REG-1:0] r_data     [N_SLOTS];
  logic [I_BL_ARC_PC-1:0]   r_next_pc  [N_SLOTS];
  logic [I_BL_TRAPC-1:0]    r_trapc    [N_SLOTS];

  logic w_commit;
  logic w_cur_ok;
  logic w_spec_ok;
  logic w_flush;
  logic w_book;
  logic w_fill;

  function automatic slot_t next_slot(input slot_t p);
    return (p == LAST_SLOT) ? FIRST_SLOT : p + FIRST_SLOT;
  endfunction

  // Commit reads the registered done bit, so a fill reaches commit one cycle later.
  assign w_commit  = r_valid[r_head] & r_done[r_head] & ~c_pause;
  assign w_cur_ok  = (r_trapc[r_head] == '0);
  assign w_spec_ok = w_cur_ok & (r_next_pc[r_head] == r_spec_pc[r_head]);
  assign w_flush   = w_commit & ~w_spec_ok;

  // Full is judged on the pre-edge count: a same-cycle commit does not free a slot.
  assign w_book = c_req & ~c_pause & (r_count != LAST_SLOT) & ~w_flush;
  assign w_fill = (f_i_preg_rd != '0) & ~c_pause & r_valid[f_i_preg_rd] & ~w_flush;

  assign s_book    = w_book;
  assign i_preg_rd = r_tail;

  // Ring pointers, occupancy, slot status bits and architectural PC/privilege.
  always_ff @(posedge c_clock) begin
    if (c_reset) begin
      r_valid    <= '0;
      r_done     <= '0;
      r_head     <= FIRST_SLOT;
      r_tail     <= FIRST_SLOT;
      r_count    <= '0;
      r_arch_pc  <= RESET_PC;
      r_arch_pvl <= '0;
    end else if (w_flush) begin
      // The head retires; everything younger is discarded along with any
      // booking or fill that arrived in the same cycle.
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= FIRST_SLOT;
      r_tail  <= FIRST_SLOT;
      r_count <= '0;
      if (w_cur_ok) begin
        r_arch_pc <= r_next_pc[r_head];
      end else begin
        r_arch_pc  <= TRAP_PC;
        r_arch_pvl <= '0;
      end
    end else begin
      if (w_fill) begin
        r_done[f_i_preg_rd] <= 1'b1;
      end
      if (w_book) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= next_slot(r_tail);
      end
      // Placed after the fill so a refill of the retiring head cannot revive it.
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= next_slot(r_head);
        r_arch_pc       <= r_next_pc[r_head];
      end
      case ({w_book, w_commit})
        2'b10:   r_count <= r_count + FIRST_SLOT;
        2'b01:   r_count <= r_count - FIRST_SLOT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload capture on booking and on fill.
  // NOTE: payload arrays carry no reset; valid/done gate every read, so
  // stale contents are never observed and the arrays can map to plain RAM.
  always_ff @(posedge c_clock) begin
    if (w_book) begin
      r_spec_pc[r_tail]  <= i_spec_pc;
      r_spec_pvl[r_tail] <= i_spec_pvl;
      r_areg_rd[r_tail]  <= i_areg_rd;
      r_op[r_tail]       <= c_op;
    end
    if (w_fill) begin
      r_data[f_i_preg_rd]    <= f_d_preg_rd;
      r_next_pc[f_i_preg_rd] <= f_i_arch_nextPc;
      r_trapc[f_i_preg_rd]   <= f_s_trapC;
    end
  end

  // Commit and register broadcast, all zero when nothing retires.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    s_enable    = w_commit;
    s_cur       = 1'b0;
    s_cur_fcode = '0;
    s_spec      = 1'b0;
    cur_i_pc    = '0;
    cur_i_pvl   = '0;
    recov_i_pc  = '0;
    recov_i_pvl = '0;
    c_op_cm     = '0;
    i_preg_rb1  = '0;
    i_areg_rb1  = '0;
    d_preg_rb1  = '0;
    if (w_commit) begin
      s_cur       = w_cur_ok;
      s_cur_fcode = r_trapc[r_head];
      s_spec      = w_spec_ok;
      cur_i_pc    = r_arch_pc;
      cur_i_pvl   = r_arch_pvl;
      c_op_cm     = r_op[r_head];
      if (w_cur_ok) begin
        recov_i_pc  = r_next_pc[r_head];
        recov_i_pvl = r_arch_pvl;
        if (r_areg_rd[r_head] != '0) begin
          i_preg_rb1 = r_head;
          i_areg_rb1 = r_areg_rd[r_head];
          d_preg_rb1 = r_data[r_head];
        end
      end else begin
        recov_i_pc  = TRAP_PC;
        recov_i_pvl = '0;
      end
    end
  end

endmodule

// File: tb/tb_rob_book_responder.sv
// Directed bench for rob_book_responder: booking, fill, in-order commit,
// pointer wrap, full handling, mispredict and trap flushes, pause and reset.
module tb_rob_book_responder;

  logic        c_clock;
  logic        c_reset;
  logic        c_pause;
  logic        c_req;
  logic [31:0] i_spec_pc;
  logic [1:0]  i_spec_pvl;
  logic [4:0]  i_areg_rd;
  logic [5:0]  c_op;
  logic        s_book;
  logic [3:0]  i_preg_rd;
  logic [3:0]  f_i_preg_rd;
  logic [31:0] f_d_preg_rd;
  logic [31:0] f_i_arch_nextPc;
  logic [3:0]  f_s_trapC;
  logic        s_enable;
  logic        s_cur;
  logic [3:0]  s_cur_fcode;
  logic        s_spec;
  logic [31:0] cur_i_pc;
  logic [1:0]  cur_i_pvl;
  logic [31:0] recov_i_pc;
  logic [1:0]  recov_i_pvl;
  logic [5:0]  c_op_cm;
  logic [3:0]  i_preg_rb1;
  logic [4:0]  i_areg_rb1;
  logic [31:0] d_preg_rb1;

  int checks;
  int errors;

  rob_book_responder dut (
    .c_clock         (c_clock),
    .c_reset         (c_reset),
    .c_pause         (c_pause),
    .c_req           (c_req),
    .i_spec_pc       (i_spec_pc),
    .i_spec_pvl      (i_spec_pvl),
    .i_areg_rd       (i_areg_rd),
    .c_op            (c_op),
    .s_book          (s_book),
    .i_preg_rd       (i_preg_rd),
    .f_i_preg_rd     (f_i_preg_rd),
    .f_d_preg_rd     (f_d_preg_rd),
    .f_i_arch_nextPc (f_i_arch_nextPc),
    .f_s_trapC       (f_s_trapC),
    .s_enable        (s_enable),
    .s_cur           (s_cur),
    .s_cur_fcode     (s_cur_fcode),
    .s_spec          (s_spec),
    .cur_i_pc        (cur_i_pc),
    .cur_i_pvl       (cur_i_pvl),
    .recov_i_pc      (recov_i_pc),
    .recov_i_pvl     (recov_i_pvl),
    .c_op_cm         (c_op_cm),
    .i_preg_rb1      (i_preg_rb1),
    .i_areg_rb1      (i_areg_rb1),
    .d_preg_rb1      (d_preg_rb1)
  );

  initial c_clock = 1'b0;
  always #5 c_clock = ~c_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge c_clock);
    #1;
  endtask

  task automatic idle();
    c_req           = 1'b0;
    i_spec_pc       = '0;
    i_spec_pvl      = '0;
    i_areg_rd       = '0;
    c_op            = '0;
    f_i_preg_rd     = '0;
    f_d_preg_rd     = '0;
    f_i_arch_nextPc = '0;
    f_s_trapC       = '0;
  endtask

  task automatic book_in(input logic [31:0] pc, input logic [4:0] areg, input logic [5:0] op);
    c_req      = 1'b1;
    i_spec_pc  = pc;
    i_spec_pvl = '0;
    i_areg_rd  = areg;
    c_op       = op;
  endtask

  task automatic fill_in(input logic [3:0] slot, input logic [31:0] data,
                         input logic [31:0] npc, input logic [3:0] trap);
    f_i_preg_rd     = slot;
    f_d_preg_rd     = data;
    f_i_arch_nextPc = npc;
    f_s_trapC       = trap;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    idle();
    c_pause = 1'b0;
    c_reset = 1'b1;
    tick();
    tick();
    c_reset = 1'b0;
    #1;
    check("rst_enable", s_enable, 0);
    check("rst_tail", i_preg_rd, 1);
    check("rst_book_idle", s_book, 0);
    check("rst_rb_idx", i_preg_rb1, 0);
    check("rst_cur_pc", cur_i_pc, 0);
    tick();

    // Three bookings, then a fill of slot 1 commits it one cycle later.
    book_in(32'd4, 5'd5, 6'd1);
    #1;
    check("t1_book1", s_book, 1);
    check("t1_idx1", i_preg_rd, 1);
    tick();
    book_in(32'd8, 5'd6, 6'd2);
    #1;
    check("t1_idx2", i_preg_rd, 2);
    tick();
    book_in(32'd12, 5'd0, 6'd3);
    #1;
    check("t1_idx3", i_preg_rd, 3);
    tick();
    idle();
    fill_in(4'd1, 32'hAA, 32'd4, 4'd0);
    #1;
    check("t1_fill_not_yet", s_enable, 0);
    tick();
    idle();
    #1;
    check("t1_enable", s_enable, 1);
    check("t1_spec", s_spec, 1);
    check("t1_cur", s_cur, 1);
    check("t1_cur_pc", cur_i_pc, 0);
    check("t1_rb_idx", i_preg_rb1, 1);
    check("t1_rb_areg", i_areg_rb1, 5);
    check("t1_rb_data", d_preg_rb1, 32'hAA);
    check("t1_op", c_op_cm, 1);
    check("t1_recov_pc", recov_i_pc, 4);
    tick();

    // Out-of-order fills, in-order commits.
    fill_in(4'd3, 32'h33, 32'd12, 4'd0);
    #1;
    check("t2_no_commit_a", s_enable, 0);
    tick();
    idle();
    #1;
    check("t2_no_commit_b", s_enable, 0);
    tick();
    fill_in(4'd2, 32'h22, 32'd8, 4'd0);
    #1;
    check("t2_no_commit_c", s_enable, 0);
    tick();
    idle();
    #1;
    check("t2_c2_enable", s_enable, 1);
    check("t2_c2_idx", i_preg_rb1, 2);
    check("t2_c2_areg", i_areg_rb1, 6);
    check("t2_c2_data", d_preg_rb1, 32'h22);
    check("t2_c2_pc", cur_i_pc, 4);
    tick();
    #1;
    check("t2_c3_enable", s_enable, 1);
    check("t2_c3_pc", cur_i_pc, 8);
    check("t2_c3_no_rb", i_preg_rb1, 0);
    check("t2_c3_spec", s_spec, 1);
    tick();
    #1;
    check("t2_empty", s_enable, 0);

    // Fill the buffer from a fresh reset, then wrap past slot 15 to slot 1.
    c_reset = 1'b1;
    tick();
    c_reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      book_in(32'(4 * (i + 1)), 5'(i + 1), 6'(i));
      #1;
      check($sformatf("t3_book_%0d", i), s_book, 1);
      check($sformatf("t3_idx_%0d", i), i_preg_rd, 32'(i + 1));
      tick();
    end
    book_in(32'h80, 5'd20, 6'd10);
    fill_in(4'd1, 32'h11, 32'd4, 4'd0);
    #1;
    check("t3_full", s_book, 0);
    check("t3_tail_wrapped", i_preg_rd, 1);
    tick();
    f_i_preg_rd = '0;
    #1;
    check("t3_commit", s_enable, 1);
    check("t3_full_precount", s_book, 0);
    check("t3_rb_idx", i_preg_rb1, 1);
    check("t3_rb_data", d_preg_rb1, 32'h11);
    tick();
    book_in(32'd8 + 32'h58, 5'd7, 6'd9);
    #1;
    check("t3_wrap_book", s_book, 1);
    check("t3_wrap_idx", i_preg_rd, 1);
    tick();

    // Mispredict at slot 2 (spec_pc 8, resolved 0x40) flushes the buffer.
    idle();
    fill_in(4'd2, 32'h22, 32'h40, 4'd0);
    #1;
    tick();
    f_i_preg_rd = '0;
    book_in(32'h90, 5'd1, 6'd1);
    #1;
    check("t4_enable", s_enable, 1);
    check("t4_cur", s_cur, 1);
    check("t4_spec", s_spec, 0);
    check("t4_recov_pc", recov_i_pc, 32'h40);
    check("t4_recov_pvl", recov_i_pvl, 0);
    check("t4_cur_pc", cur_i_pc, 4);
    check("t4_rb_idx", i_preg_rb1, 2);
    check("t4_no_book", s_book, 0);
    tick();
    book_in(32'h44, 5'd3, 6'd5);
    #1;
    check("t4_empty", s_enable, 0);
    check("t4_idx_reset", i_preg_rd, 1);
    check("t4_book_again", s_book, 1);
    tick();
    idle();
    fill_in(4'd1, 32'h55, 32'h44, 4'd0);
    #1;
    tick();
    idle();
    #1;
    check("t4_arch_pc", cur_i_pc, 32'h40);
    check("t4_spec_ok", s_spec, 1);
    tick();

    // Trap at slot 2; the same-cycle booking and fill are dropped.
    book_in(32'h48, 5'd4, 6'd7);
    #1;
    check("t5_idx2", i_preg_rd, 2);
    tick();
    book_in(32'h4c, 5'd8, 6'd8);
    #1;
    check("t5_idx3", i_preg_rd, 3);
    tick();
    idle();
    fill_in(4'd2, 32'h99, 32'h48, 4'd3);
    #1;
    tick();
    book_in(32'h200, 5'd10, 6'd2);
    fill_in(4'd3, 32'h66, 32'h4c, 4'd0);
    #1;
    check("t5_enable", s_enable, 1);
    check("t5_cur", s_cur, 0);
    check("t5_fcode", s_cur_fcode, 3);
    check("t5_spec", s_spec, 0);
    check("t5_recov_pc", recov_i_pc, 32'h100);
    check("t5_recov_pvl", recov_i_pvl, 0);
    check("t5_no_rb", i_preg_rb1, 0);
    check("t5_cur_pc", cur_i_pc, 32'h44);
    check("t5_flush_blocks_book", s_book, 0);
    tick();
    book_in(32'h104, 5'd9, 6'h3f);
    f_i_preg_rd = '0;
    #1;
    check("t5_empty", s_enable, 0);
    check("t5_idx_reset", i_preg_rd, 1);
    check("t5_book", s_book, 1);
    tick();
    idle();
    fill_in(4'd1, 32'h77, 32'h104, 4'd0);
    #1;
    tick();
    idle();
    #1;
    check("t5_trap_pc", cur_i_pc, 32'h100);
    check("t5_trap_pvl", cur_i_pvl, 0);
    check("t5_after_spec", s_spec, 1);
    check("t5_op", c_op_cm, 6'h3f);
    check("t5_rb_areg", i_areg_rb1, 9);

    // Pause with a done head and a pending request freezes everything.
    c_pause = 1'b1;
    book_in(32'h300, 5'd1, 6'd1);
    #1;
    check("t6_pause_enable", s_enable, 0);
    check("t6_pause_book", s_book, 0);
    check("t6_pause_rb", i_preg_rb1, 0);
    tick();
    tick();
    c_pause = 1'b0;
    idle();
    #1;
    check("t6_resume_enable", s_enable, 1);
    check("t6_resume_pc", cur_i_pc, 32'h100);
    check("t6_resume_data", d_preg_rb1, 32'h77);
    check("t6_resume_tail", i_preg_rd, 2);
    tick();

    // Five valid slots, then reset (with a request pending) empties the buffer.
    for (int i = 0; i < 5; i++) begin
      book_in(32'h400 + 32'(4 * i), 5'(i + 1), 6'(i));
      #1;
      check($sformatf("t6_fill_idx_%0d", i), i_preg_rd, 32'(i + 2));
      tick();
    end
    c_reset = 1'b1;
    book_in(32'h500, 5'd2, 6'd2);
    tick();
    c_reset = 1'b0;
    book_in(32'd4, 5'd5, 6'd1);
    #1;
    check("t6_rst_idx", i_preg_rd, 1);
    check("t6_rst_book", s_book, 1);
    check("t6_rst_enable", s_enable, 0);
    tick();
    idle();
    fill_in(4'd1, 32'hBB, 32'd4, 4'd0);
    #1;
    tick();
    idle();
    #1;
    check("t6_rst_commit", s_enable, 1);
    check("t6_rst_arch_pc", cur_i_pc, 0);
    check("t6_rst_rb_idx", i_preg_rb1, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
